// File: rtl/input_cmd_hub_if.sv
// Command hub bus: source-side capture handshake and consumer-side FIFO head.
interface input_cmd_hub_if #(
  parameter int CH_CNT     = 2,
  parameter int DATA_W     = 3,
  parameter int LOG2_DEPTH = 2
);
  localparam int CH_W = (CH_CNT > 1) ? $clog2(CH_CNT) : 1;

  logic [CH_CNT-1:0]        src_ready;
  logic [CH_CNT*DATA_W-1:0] src_data;
  logic [CH_CNT-1:0]        ch_mask;
  logic [CH_CNT-1:0]        src_read_fin;
  logic                     dst_ready;
  logic [CH_W+DATA_W-1:0]   dst_data;
  logic                     dst_read_fin;
  logic [7:0]               drop_cnt;
  logic [LOG2_DEPTH:0]      level;

  modport master (
    output src_ready, src_data, ch_mask, dst_read_fin,
    input  src_read_fin, dst_ready, dst_data, drop_cnt, level
  );

  modport slave (
    input  src_ready, src_data, ch_mask, dst_read_fin,
    output src_read_fin, dst_ready, dst_data, drop_cnt, level
  );
endinterface

// File: rtl/input_cmd_hub.sv
// Round-robin command collector: captures one armed source per cycle into a
// first-word fall-through FIFO tagged with the source id.
module input_cmd_hub #(
  parameter int CH_CNT       = 2,
  parameter int DATA_W       = 3,
  parameter int LOG2_DEPTH   = 2,
  parameter int DROP_ON_FULL = 0
) (
  input logic              clock,
  input logic              reset,
  input_cmd_hub_if.slave   hub
);
  localparam int CH_W  = (CH_CNT > 1) ? $clog2(CH_CNT) : 1;
  localparam int DEPTH = 1 << LOG2_DEPTH;
  localparam int ENT_W = CH_W + DATA_W;
  localparam logic [LOG2_DEPTH:0] FULL_LVL = (LOG2_DEPTH+1)'(DEPTH);

  logic [CH_CNT-1:0]     armed;
  logic [CH_CNT-1:0]     eligible;
  logic [CH_CNT-1:0]     gnt_vec;
  logic [CH_CNT-1:0]     fin_q;
  logic [CH_W-1:0]       rr_ptr;
  logic [CH_W-1:0]       rr_nxt;
  logic [CH_W-1:0]       gnt_id;
  logic [CH_W-1:0]       cand;
  logic [DATA_W-1:0]     sel_data;
  logic                  found;
  logic                  space;
  logic                  pop;
  logic                  push;
  logic                  grant;
  logic                  drop;
  logic                  not_empty;
  logic [ENT_W-1:0]      mem [DEPTH];
  logic [LOG2_DEPTH-1:0] wr_ptr;
  logic [LOG2_DEPTH-1:0] rd_ptr;
  logic [LOG2_DEPTH:0]   level_q;
  logic [7:0]            drop_q;

  assign eligible  = hub.src_ready & hub.ch_mask & armed;
  assign not_empty = (level_q != '0);
  assign pop       = hub.dst_read_fin && not_empty;
  // A full FIFO still has room when the head leaves in the same cycle.
  assign space     = (level_q != FULL_LVL) || pop;

  // Round-robin search from rr_ptr, grant gating and source data select
  always_comb begin
    found    = 1'b0;
    gnt_id   = '0;
    cand     = '0;
    sel_data = '0;
    gnt_vec  = '0;
    for (int unsigned k = 0; k < CH_CNT; k++) begin
      cand = CH_W'((32'(rr_ptr) + k) % 32'(CH_CNT));
      if (!found && eligible[cand]) begin
        found  = 1'b1;
        gnt_id = cand;
      end
    end
    grant = found && (space || (DROP_ON_FULL != 0));
    push  = grant && space;
    drop  = grant && !space;
    if (grant) gnt_vec[gnt_id] = 1'b1;
    rr_nxt = CH_W'((32'(gnt_id) + 32'd1) % 32'(CH_CNT));
    for (int unsigned i = 0; i < CH_CNT; i++) begin
      if (gnt_id == CH_W'(i)) sel_data = hub.src_data[i*DATA_W +: DATA_W];
    end
  end

  // Arbitration state: armed bits, round-robin pointer, registered acknowledge
  always_ff @(posedge clock) begin
    if (reset) begin
      armed  <= '1;
      rr_ptr <= '0;
      fin_q  <= '0;
    end else begin
      fin_q <= gnt_vec;
      if (grant) rr_ptr <= rr_nxt;
      for (int unsigned i = 0; i < CH_CNT; i++) begin
        if (gnt_vec[i])             armed[i] <= 1'b0;
        else if (!hub.src_ready[i]) armed[i] <= 1'b1;
      end
    end
  end

  // FIFO storage; contents are only observable through valid pointers
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= {gnt_id, sel_data};
  end

  // FIFO pointers, occupancy and saturating drop counter
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
      drop_q  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + LOG2_DEPTH'(1);
      if (pop)  rd_ptr <= rd_ptr + LOG2_DEPTH'(1);
      case ({push, pop})
        2'b10:   level_q <= level_q + (LOG2_DEPTH+1)'(1);
        2'b01:   level_q <= level_q - (LOG2_DEPTH+1)'(1);
        default: level_q <= level_q;
      endcase
      if (drop && (drop_q != 8'hFF)) drop_q <= drop_q + 8'd1;
    end
  end

  assign hub.src_read_fin = fin_q;
  assign hub.dst_ready    = not_empty;
  assign hub.dst_data     = not_empty ? mem[rd_ptr] : '0;
  assign hub.drop_cnt     = drop_q;
  assign hub.level        = level_q;
endmodule

// File: tb/tb_input_cmd_hub.sv
// Directed bench for input_cmd_hub: stalling instance (bus0) and dropping instance (bus1).
module tb_input_cmd_hub;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clock = ~clock;

  input_cmd_hub_if #(.CH_CNT(2), .DATA_W(3), .LOG2_DEPTH(2)) bus0 ();
  input_cmd_hub_if #(.CH_CNT(2), .DATA_W(3), .LOG2_DEPTH(2)) bus1 ();

  input_cmd_hub #(.CH_CNT(2), .DATA_W(3), .LOG2_DEPTH(2), .DROP_ON_FULL(0)) dut0 (
    .clock(clock), .reset(reset), .hub(bus0)
  );
  input_cmd_hub #(.CH_CNT(2), .DATA_W(3), .LOG2_DEPTH(2), .DROP_ON_FULL(1)) dut1 (
    .clock(clock), .reset(reset), .hub(bus1)
  );

  typedef struct {
    logic [1:0] rdy;
    logic [5:0] data;
    logic [1:0] mask;
    logic       pop;
    logic [1:0] fin;
    logic       vld;
    logic [3:0] dout;
    logic [2:0] lvl;
  } vec_t;

  vec_t vecs[11];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push0(input logic [2:0] d);
    bus0.src_data  = {3'd0, d};
    bus0.src_ready = 2'b01;
    tick();
    bus0.src_ready = 2'b00;
    tick();
  endtask

  task automatic push1(input logic [2:0] d);
    bus1.src_data  = {3'd0, d};
    bus1.src_ready = 2'b01;
    tick();
    bus1.src_ready = 2'b00;
    tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus0.src_ready = '0; bus0.dst_read_fin = 1'b0; bus0.ch_mask = 2'b11;
    bus1.src_ready = '0; bus1.dst_read_fin = 1'b0; bus1.ch_mask = 2'b11;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int fins;
    int g;
    logic [1:0] f;

    vecs[0]  = '{2'b01, 6'b000_101, 2'b11, 1'b0, 2'b01, 1'b1, 4'b0101, 3'd1};
    vecs[1]  = '{2'b00, 6'b000_101, 2'b11, 1'b0, 2'b00, 1'b1, 4'b0101, 3'd1};
    vecs[2]  = '{2'b11, 6'b011_110, 2'b11, 1'b0, 2'b10, 1'b1, 4'b0101, 3'd2};
    vecs[3]  = '{2'b11, 6'b011_110, 2'b11, 1'b1, 2'b01, 1'b1, 4'b1011, 3'd2};
    vecs[4]  = '{2'b11, 6'b011_110, 2'b11, 1'b1, 2'b00, 1'b1, 4'b0110, 3'd1};
    vecs[5]  = '{2'b00, 6'b011_110, 2'b11, 1'b1, 2'b00, 1'b0, 4'b0000, 3'd0};
    vecs[6]  = '{2'b11, 6'b111_001, 2'b01, 1'b0, 2'b01, 1'b1, 4'b0001, 3'd1};
    vecs[7]  = '{2'b10, 6'b111_001, 2'b11, 1'b0, 2'b10, 1'b1, 4'b0001, 3'd2};
    vecs[8]  = '{2'b00, 6'b111_001, 2'b11, 1'b1, 2'b00, 1'b1, 4'b1111, 3'd1};
    vecs[9]  = '{2'b00, 6'b111_001, 2'b11, 1'b1, 2'b00, 1'b0, 4'b0000, 3'd0};
    vecs[10] = '{2'b00, 6'b111_001, 2'b11, 1'b1, 2'b00, 1'b0, 4'b0000, 3'd0};

    bus0.src_ready = '0; bus0.src_data = '0; bus0.ch_mask = 2'b11; bus0.dst_read_fin = 1'b0;
    bus1.src_ready = '0; bus1.src_data = '0; bus1.ch_mask = 2'b11; bus1.dst_read_fin = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    // reset state
    check("rst_fin",   32'(bus0.src_read_fin), 32'd0);
    check("rst_vld",   32'(bus0.dst_ready),    32'd0);
    check("rst_data",  32'(bus0.dst_data),     32'd0);
    check("rst_drop",  32'(bus0.drop_cnt),     32'd0);
    check("rst_level", 32'(bus0.level),        32'd0);

    // table-driven arbitration/FIFO vectors
    for (int i = 0; i < 11; i++) begin
      bus0.src_ready    = vecs[i].rdy;
      bus0.src_data     = vecs[i].data;
      bus0.ch_mask      = vecs[i].mask;
      bus0.dst_read_fin = vecs[i].pop;
      tick();
      check($sformatf("vec%0d_fin", i),   32'(bus0.src_read_fin), 32'(vecs[i].fin));
      check($sformatf("vec%0d_vld", i),   32'(bus0.dst_ready),    32'(vecs[i].vld));
      check($sformatf("vec%0d_data", i),  32'(bus0.dst_data),     32'(vecs[i].dout));
      check($sformatf("vec%0d_level", i), 32'(bus0.level),        32'(vecs[i].lvl));
    end

    // stall when full, resume via same-cycle pop
    do_reset();
    for (int k = 1; k <= 4; k++) push0(3'(k));
    check("full_level", 32'(bus0.level), 32'd4);
    check("full_head",  32'(bus0.dst_data), 32'h1);
    bus0.src_data  = {3'd0, 3'd5};
    bus0.src_ready = 2'b01;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("stall_fin", 32'(bus0.src_read_fin), 32'd0);
    end
    check("stall_level", 32'(bus0.level), 32'd4);
    bus0.dst_read_fin = 1'b1;
    tick();
    check("resume_fin",   32'(bus0.src_read_fin), 32'b01);
    check("resume_level", 32'(bus0.level), 32'd4);
    check("resume_head",  32'(bus0.dst_data), 32'h2);
    bus0.dst_read_fin = 1'b0;
    bus0.src_ready = 2'b00;
    tick();
    bus0.src_data  = {3'd0, 3'd6};
    bus0.src_ready = 2'b01;
    tick();
    check("sixth_fin", 32'(bus0.src_read_fin), 32'd0);
    bus0.src_ready = 2'b00;
    for (int k = 2; k <= 5; k++) begin
      check("drain_data", 32'(bus0.dst_data), 32'(k));
      bus0.dst_read_fin = 1'b1;
      tick();
    end
    bus0.dst_read_fin = 1'b0;
    check("drain_level", 32'(bus0.level), 32'd0);
    check("nodrop_cnt",  32'(bus0.drop_cnt), 32'd0);

    // held ready yields a single capture until it goes low
    do_reset();
    bus0.dst_read_fin = 1'b1;
    bus0.src_data  = {3'd0, 3'd3};
    bus0.src_ready = 2'b01;
    fins = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (bus0.src_read_fin[0]) fins++;
    end
    check("hold_acks", 32'(fins), 32'd1);
    bus0.src_ready = 2'b00;
    tick();
    bus0.src_ready = 2'b01;
    tick();
    check("recapture_fin", 32'(bus0.src_read_fin), 32'b01);
    bus0.src_ready = 2'b00;
    bus0.dst_read_fin = 1'b0;

    // two reactive sources, consumer popping every cycle
    do_reset();
    bus0.dst_read_fin = 1'b1;
    bus0.src_data  = {3'd2, 3'd1};
    bus0.src_ready = 2'b11;
    for (int k = 0; k < 8; k++) begin
      tick();
      f = bus0.src_read_fin;
      g = (f == 2'b01) ? 0 : (f == 2'b10) ? 1 : 3;
      check("rr_grant", 32'(g), 32'(k % 2));
      bus0.src_ready = ~f;
    end
    bus0.src_ready = 2'b00;
    bus0.dst_read_fin = 1'b0;

    // drop-on-full instance: ack and discard, counter saturates
    do_reset();
    for (int k = 1; k <= 4; k++) push1(3'(k));
    check("d_full_level", 32'(bus1.level), 32'd4);
    fins = 0;
    bus1.src_data = {3'd0, 3'd7};
    for (int k = 0; k < 300; k++) begin
      bus1.src_ready = 2'b01;
      tick();
      if (bus1.src_read_fin[0]) fins++;
      bus1.src_ready = 2'b00;
      tick();
      if (bus1.src_read_fin[0]) fins++;
    end
    check("d_acks",  32'(fins), 32'd300);
    check("d_cnt",   32'(bus1.drop_cnt), 32'd255);
    check("d_level", 32'(bus1.level), 32'd4);
    for (int k = 1; k <= 4; k++) begin
      check("d_drain_data", 32'(bus1.dst_data), 32'(k));
      bus1.dst_read_fin = 1'b1;
      tick();
    end
    bus1.dst_read_fin = 1'b0;
    check("d_drain_level", 32'(bus1.level), 32'd0);

    // reset mid-operation with level 3 and an acknowledge in flight
    push1(3'd1);
    push1(3'd2);
    bus1.src_data  = {3'd4, 3'd3};
    bus1.src_ready = 2'b01;
    tick();
    check("pre_rst_level", 32'(bus1.level), 32'd3);
    check("pre_rst_fin",   32'(bus1.src_read_fin), 32'b01);
    reset = 1'b1;
    bus1.src_ready = 2'b10;
    tick();
    check("mid_rst_fin",  32'(bus1.src_read_fin), 32'd0);
    check("mid_rst_vld",  32'(bus1.dst_ready), 32'd0);
    check("mid_rst_lvl",  32'(bus1.level), 32'd0);
    check("mid_rst_drop", 32'(bus1.drop_cnt), 32'd0);
    check("mid_rst_data", 32'(bus1.dst_data), 32'd0);
    reset = 1'b0;
    bus1.src_ready = 2'b00;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/input_cmd_hub.md
INPUT_CMD_HUB -- requirements
Module: input_cmd_hub

Interface
REQ-001 SHALL have parameter CH_CNT, default 2: number of command sources, 1..8.
REQ-002 SHALL have parameter DATA_W, default 3: command width per source.
REQ-003 SHALL have parameter LOG2_DEPTH, default 2: FIFO depth = 2**LOG2_DEPTH.
REQ-004 SHALL have parameter DROP_ON_FULL, default 0: 0 = stall sources when full, 1 = ack and discard.
REQ-005 SHALL define CH_W = max(1, ceil(log2(CH_CNT))).
REQ-006 SHALL have one clock and a synchronous, active-high reset; port list follows.
REQ-007 clock  in  1  system clock; all logic on rising edge.
REQ-008 reset  in  1  synchronous, active-high reset.
REQ-009 src_ready  in  CH_CNT  bit i = source i holds a new command.
REQ-010 src_data  in  CH_CNT*DATA_W  command of source i in bits [i*DATA_W +: DATA_W].
REQ-011 ch_mask  in  CH_CNT  bit i = 1 enables source i.
REQ-012 src_read_fin  out  CH_CNT  one-cycle capture acknowledge to source i.
REQ-013 dst_ready  out  1  FIFO head valid.
REQ-014 dst_data  out  CH_W+DATA_W  head entry {channel id, command}.
REQ-015 dst_read_fin  in  1  consumer pop strobe.
REQ-016 drop_cnt  out  8  count of discarded commands, saturating.
REQ-017 level  out  LOG2_DEPTH+1  current FIFO occupancy.

Function
REQ-018 SHALL keep per-channel armed bit; channel i eligible only when src_ready[i]=1, ch_mask[i]=1, armed[i]=1.
REQ-019 SHALL clear armed[i] on capture; SHALL set armed[i] only in a cycle where src_ready[i]=0 is sampled.
REQ-020 SHALL capture at most one channel per cycle using round-robin starting at rr_ptr.
REQ-021 SHALL set rr_ptr = (granted+1) mod CH_CNT after each capture; unchanged otherwise.
REQ-022 SHALL assert src_read_fin[granted] for exactly the cycle after the capture decision, one bit at a time.
REQ-023 SHALL write {granted id, src_data slice} into FIFO on capture when space exists.
REQ-024 Space exists when level < depth, or level = depth and a pop occurs same cycle.
REQ-025 When no space and DROP_ON_FULL=0: SHALL grant nothing; armed bits and rr_ptr unchanged.
REQ-026 When no space and DROP_ON_FULL=1: SHALL grant, ack, discard, increment drop_cnt; saturate at 255.
REQ-027 SHALL drive dst_ready=1 iff level>0; dst_data = oldest entry; first-word fall-through.
REQ-028 Capture-to-dst_ready latency SHALL be 1 cycle when FIFO was empty.
REQ-029 dst_read_fin with dst_ready=1 SHALL pop one entry; with dst_ready=0 SHALL be ignored.
REQ-030 Simultaneous push and pop SHALL leave level unchanged; pointers wrap mod depth.
REQ-031 ch_mask change SHALL take effect on the next arbitration cycle; armed tracking continues while masked.
REQ-032 dst_data SHALL be stable while dst_ready=1 and no pop occurs.

Reset
REQ-033 On reset: src_read_fin=0, dst_ready=0, dst_data=0, drop_cnt=0, level=0, rr_ptr=0, armed all 1, FIFO empty.
REQ-034 Reset mid-operation SHALL discard FIFO contents and cancel any pending acknowledge in the next cycle.

Verification
REQ-035 CH_CNT=2: src0 ready, data 3'b101 -> src_read_fin[0] one cycle, dst_ready next cycle, dst_data={0,3'b101}, level=1.
REQ-036 Both sources ready continuously, consumer popping every cycle -> grants alternate 0,1,0,1; each source acked once until it drops ready.
REQ-037 DROP_ON_FULL=0, depth 4, no pops, 6 commands offered -> level=4, further sources unacked; after one pop the next command is acked.
REQ-038 DROP_ON_FULL=1, full FIFO, 300 further commands -> each acked, drop_cnt=255, FIFO contents unchanged.
REQ-039 Source holds ready high 10 cycles after ack -> exactly one capture; re-captured only after ready low then high.
REQ-040 Reset asserted with level=3 and pending ack -> next cycle dst_ready=0, level=0, src_read_fin=0, drop_cnt=0.
